regfile_wb_scheduler: RTL

- Schedules the single register-file write port between NUM_REQ writeback sources, e.g. the execute result and the load result.
- Keeps a busy scoreboard of destination registers that are allocated at issue and not yet written, so issue logic can detect RAW and WAW hazards.
- Sits between the writeback requesters and register_file; its rf_write_* outputs drive the register_file write port directly.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/regfile_wb_scheduler.sv | 109 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file sizing and types for the writeback scheduler slice.
package regfile_pkg;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       word_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from an internal pointer,
// which moves to one past the winner on every grant.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o
);
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] win;
  logic             any;
  int               best_d;
  int               d;

  // The winner is the requester with the smallest wrap-around distance from ptr_q.
  always_comb begin
    best_d = N;
    win    = '0;
    d      = 0;
    for (int i = 0; i < N; i++) begin
      d = i - int'(ptr_q);
      if (d < 0) d = d + N;
      if (req_i[i] && (d < best_d)) begin
        best_d = d;
        win    = PTR_W'(i);
      end
    end
    any = (best_d < N);
    for (int i = 0; i < N; i++) begin
      grant_o[i] = any && (win == PTR_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (any) begin
      ptr_q <= (win == PTR_W'(N - 1)) ? '0 : win + 1'b1;
    end
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates NUM_REQ writeback sources onto the single register-file write port
// and tracks pending destinations in a busy scoreboard. WB_BYPASS_EN adds forwarding.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = XLEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      alloc_valid,
  input  logic [ADDR_W-1:0]         alloc_address,
  output logic                      alloc_ready,
  input  logic [ADDR_W-1:0]         query_address1,
  output logic                      query_busy1,
  input  logic [ADDR_W-1:0]         query_address2,
  output logic                      query_busy2,
`ifdef WB_BYPASS_EN
  output logic [DATA_W-1:0]         query_fwd_data1,
  output logic [DATA_W-1:0]         query_fwd_data2,
`endif
  output logic [ADDR_W-1:0]         rf_write_address,
  output logic [DATA_W-1:0]         rf_write_data,
  output logic                      rf_write_enable
);
  localparam int NUM_REGS = 1 << ADDR_W;

  logic [NUM_REQ-1:0]  grant;
  logic                any_grant;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_valid),
    .grant_o (grant)
  );

  assign req_ready = grant;
  assign any_grant = |grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_address[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Bit 0 is never set, so x0 always reads idle and is always allocatable.
  assign alloc_ready = !busy_q[alloc_address];

  // The clear happens when register_file commits; set and clear never collide
  // on one register because alloc_ready is low while the bit is set.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) busy_d[wr_addr_q] = 1'b0;
    if (alloc_valid && alloc_ready) busy_d[alloc_address] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      busy_q  <= busy_d;
      wr_en_q <= any_grant && (sel_addr != '0);
      if (any_grant) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
      end
    end
  end

  assign rf_write_enable  = wr_en_q;
  assign rf_write_address = wr_addr_q;
  assign rf_write_data    = wr_data_q;

`ifdef WB_BYPASS_EN
  logic hit1;
  logic hit2;
  assign hit1            = wr_en_q && (wr_addr_q == query_address1);
  assign hit2            = wr_en_q && (wr_addr_q == query_address2);
  assign query_busy1     = busy_q[query_address1] && !hit1;
  assign query_busy2     = busy_q[query_address2] && !hit2;
  assign query_fwd_data1 = hit1 ? wr_data_q : '0;
  assign query_fwd_data2 = hit2 ? wr_data_q : '0;
`else
  assign query_busy1 = busy_q[query_address1];
  assign query_busy2 = busy_q[query_address2];
`endif
endmodule
